// File: rtl/rr_grant_enc_if.sv
// Bus bundle for rr_grant_enc: requester-side inputs and registered grant outputs.
// master = requester/decoder side, slave = arbiter.
interface rr_grant_enc_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] X;
  logic       valid;
  logic       busy;
  logic       timeout;

  modport master (output req, output done, input X, input valid, input busy, input timeout);
  modport slave  (input req, input done, output X, output valid, output busy, output timeout);
endinterface

// File: rtl/rr_grant_enc.sv
// 8-requester round-robin arbiter driving a registered 3-bit grant index to a 3-to-8 decoder.
// Optional ARB_TIMEOUT_EN: forced release after HOLD_MAX cycles, pulsing timeout.
module rr_grant_enc #(
  parameter int unsigned HOLD_MAX = 15
) (
  input logic          clk,
  input logic          rst,
  rr_grant_enc_if.slave bus
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_x, w_x_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic [2:0] w_pick, w_idx;
  logic       w_any;
  logic       w_rel_user;
  logic       w_hold_exp;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("rr_grant_enc: HOLD_MAX must be in 1..255");
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != 8'hFF) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign w_hold_exp = (r_hold_cnt == 8'(HOLD_MAX - 1));
`else
  assign w_hold_exp = 1'b0;
`endif

  // First set request scanning upward from r_ptr with 3-bit wrap.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_any && bus.req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_rel_user = bus.done | ~bus.req[r_x];

  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_valid_nxt   = r_valid;
    w_ptr_nxt     = r_ptr;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_x_nxt     = w_pick;
          w_valid_nxt = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_rel_user || w_hold_exp) begin
          w_state_nxt   = S_IDLE;
          w_valid_nxt   = 1'b0;
          w_ptr_nxt     = r_x + 3'd1;
          w_timeout_nxt = ~w_rel_user & w_hold_exp;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_valid   <= 1'b0;
      r_ptr     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_valid   <= w_valid_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.X       = r_x;
  assign bus.valid   = r_valid;
  assign bus.busy    = (r_state == S_GRANT);
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_rr_grant_enc.sv
// Scoreboard bench for rr_grant_enc: stimulus queues expected grants, a monitor checks index, length and timeout.
module tb_rr_grant_enc;

  logic clk;
  logic rst;

  rr_grant_enc_if u_if ();

  rr_grant_enc #(.HOLD_MAX(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  x;
    int unsigned len;
    logic        to;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Grant of expx held for h cycles, released by done; keep leaves req asserted afterwards.
  task automatic grant_done(input logic [7:0] reqv, input logic [2:0] expx,
                            input int unsigned h, input bit keep);
    q.push_back('{x: expx, len: h, to: 1'b0});
    u_if.req = reqv;
    cyc(1);
    if (h > 1) cyc(h - 1);
    u_if.done = 1'b1;
    cyc(1);
    u_if.done = 1'b0;
    u_if.req  = keep ? reqv : 8'h00;
  endtask

  // Monitor: grant start checks X, grant end checks length and timeout.
  initial begin
    logic        prev_v;
    int unsigned run;
    exp_t        e;
    prev_v = 1'b0;
    run    = 0;
    forever begin
      @(negedge clk);
      if (u_if.valid && !prev_v) begin
        run = 1;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant_unexpected actual X=%0d required=no grant", u_if.X);
        end else begin
          chk("grant_x", 32'(u_if.X), 32'(q[0].x));
        end
      end else if (u_if.valid) begin
        run++;
      end
      if (!u_if.valid && prev_v) begin
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("grant_len", run, e.len);
          chk("timeout_pulse", 32'(u_if.timeout), 32'(e.to));
        end
      end else if (u_if.timeout) begin
        checks++; errors++;
        $display("FAIL timeout_stray actual=1 required=0");
      end
      prev_v = u_if.valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    u_if.req  = 8'h00;
    u_if.done = 1'b0;

    // Reset then idle
    cyc(2);
    chk("rst_x", 32'(u_if.X), 0);
    chk("rst_valid", 32'(u_if.valid), 0);
    chk("rst_busy", 32'(u_if.busy), 0);
    chk("rst_timeout", 32'(u_if.timeout), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("idle_valid", 32'(u_if.valid), 0);
      chk("idle_busy", 32'(u_if.busy), 0);
      chk("idle_x", 32'(u_if.X), 0);
    end

    // Single requester, then ptr=3 picks 3 over 2
    q.push_back('{x: 3'd2, len: 1, to: 1'b0});
    u_if.req = 8'b0000_0100;
    cyc(1);
    chk("single_valid", 32'(u_if.valid), 1);
    chk("single_busy", 32'(u_if.busy), 1);
    chk("single_x", 32'(u_if.X), 2);
    u_if.done = 1'b1;
    cyc(1);
    u_if.done = 1'b0;
    u_if.req  = 8'h00;
    chk("single_release", 32'(u_if.valid), 0);
    chk("single_busy_off", 32'(u_if.busy), 0);
    grant_done(8'h0C, 3'd3, 2, 1'b0);

    // Round-robin fairness from ptr=0
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int i = 0; i < 9; i++)
      grant_done(8'hFF, 3'(i % 8), 32'(1 + i % 3), i != 8);

    // Wrap: grant 6 -> ptr=7, then 7 before 0
    grant_done(8'h40, 3'd6, 1, 1'b0);
    grant_done(8'h81, 3'd7, 1, 1'b1);
    grant_done(8'h81, 3'd0, 1, 1'b0);

    // Request drop releases with no timeout
    q.push_back('{x: 3'd3, len: 2, to: 1'b0});
    u_if.req = 8'h08;
    cyc(2);
    u_if.req = 8'h00;
    cyc(1);
    chk("drop_valid", 32'(u_if.valid), 0);

    // Reset mid-grant
    q.push_back('{x: 3'd3, len: 2, to: 1'b0});
    u_if.req = 8'h08;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    u_if.req = 8'h00;
    chk("midrst_valid", 32'(u_if.valid), 0);
    chk("midrst_x", 32'(u_if.X), 0);
    chk("midrst_busy", 32'(u_if.busy), 0);
    grant_done(8'hFF, 3'd0, 1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Forced release after HOLD_MAX=4, one idle cycle, regrant
    q.push_back('{x: 3'd1, len: 4, to: 1'b1});
    q.push_back('{x: 3'd1, len: 4, to: 1'b1});
    u_if.req = 8'h02;
    cyc(4);
    chk("to_still_valid", 32'(u_if.valid), 1);
    cyc(1);
    chk("to_pulse", 32'(u_if.timeout), 1);
    cyc(1);
    chk("to_pulse_once", 32'(u_if.timeout), 0);
    chk("to_regrant", 32'(u_if.valid), 1);
    cyc(4);
    u_if.req = 8'h00;
    // done coinciding with expiry suppresses the pulse
    grant_done(8'h02, 3'd1, 4, 1'b0);
`else
    q.push_back('{x: 3'd1, len: 25, to: 1'b0});
    u_if.req = 8'h02;
    cyc(25);
    chk("notimeout_valid", 32'(u_if.valid), 1);
    u_if.done = 1'b1;
    cyc(1);
    u_if.done = 1'b0;
    u_if.req  = 8'h00;
`endif

    cyc(3);
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
